// File: rtl/fp32_addsub_seq.sv
// Purpose: multi-cycle IEEE-754 FP32 adder/subtractor, one operation in flight at a time.
// Latency: 5 cycles from input handshake to out_valid_o (2 cycles for NaN/inf bypass).
// Backpressure: result held in DONE until out_ready_i; in_ready_o is low from accept until after the output handshake.
// Ports: clk_i, rst_ni (async, active-low), in_valid_i/in_ready_o, add1_i/add2_i operands,
//        command_i (1 = A+B, 0 = A-B), out_valid_o/out_ready_i, result_o, exc_flags_o {invalid, overflow, inexact}.
// Build option: define FP32_ADDSUB_RNE_EN for round-to-nearest-even; otherwise rounding is toward zero.
module fp32_addsub_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] add1_i,
    input  logic [31:0] add2_i,
    input  logic        command_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [2:0]  exc_flags_o
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;

    state_t             state_q;
    logic [31:0]        a_q, b_q;
    logic               cmd_q;
    // unpacked operands (sb_q is the effective sign of B)
    logic               sa_q, sb_q;
    logic [7:0]         ea_q, eb_q;
    logic [23:0]        ma_q, mb_q;
    logic               spec_q, spec_inv_q;
    logic [31:0]        spec_res_q;
    // aligned operands: big significand, small significand with G/R and sticky
    logic               sign_q, eff_sub_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mbig_q;
    logic [25:0]        msml_q;
    logic               sticky_q;
    // raw sum: carry, 24 significand bits, G, R, S
    logic [27:0]        sum_q;
    // normalized significand: 24 bits + G, R, S
    logic [26:0]        nrm_q;
    logic               zero_q, uf_q;
    // registered outputs
    logic               in_ready_q, out_valid_q;
    logic [31:0]        result_q;
    logic [2:0]         flags_q;

    // ---------------- UNPACK ----------------
    logic        sb_eff_d;
    logic [23:0] ma_d, mb_d;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        spec_d, spec_inv_d;
    logic [31:0] spec_res_d;

    always_comb begin
        sb_eff_d   = b_q[31] ^ ~cmd_q;
        // exp == 0 covers both zero and denormal: flushed to a zero significand
        ma_d       = (a_q[30:23] != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
        mb_d       = (b_q[30:23] != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
        nan_a      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        nan_b      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        inf_a      = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        inf_b      = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        spec_d     = nan_a | nan_b | inf_a | inf_b;
        spec_inv_d = 1'b0;
        spec_res_d = QNAN;
        if (nan_a || nan_b) begin
            spec_inv_d = 1'b1;
        end else if (inf_a && inf_b && (a_q[31] != sb_eff_d)) begin
            spec_inv_d = 1'b1;
        end else if (inf_a) begin
            spec_res_d = {a_q[31], 8'hFF, 23'd0};
        end else if (inf_b) begin
            spec_res_d = {sb_eff_d, 8'hFF, 23'd0};
        end
    end

    // ---------------- ALIGN ----------------
    logic        a_ge_b, big_s_d, small_s_d;
    logic [7:0]  big_e_d, small_e_d, diff_d;
    logic [23:0] big_m_d, small_m_d;
    logic [49:0] ext_d;
    logic [25:0] al_m_d;
    logic        al_st_d;

    always_comb begin
        a_ge_b    = {ea_q, ma_q} >= {eb_q, mb_q};
        big_s_d   = a_ge_b ? sa_q : sb_q;
        small_s_d = a_ge_b ? sb_q : sa_q;
        big_e_d   = a_ge_b ? ea_q : eb_q;
        small_e_d = a_ge_b ? eb_q : ea_q;
        big_m_d   = a_ge_b ? ma_q : mb_q;
        small_m_d = a_ge_b ? mb_q : ma_q;
        diff_d    = big_e_d - small_e_d;
        // top 24 bits: shifted significand, next 2: G/R, remaining bits collapse into sticky
        ext_d     = {small_m_d, 26'd0} >> diff_d;
        if (diff_d >= 8'd26) begin
            al_m_d  = 26'd0;
            al_st_d = |small_m_d;
        end else begin
            al_m_d  = ext_d[49:24];
            al_st_d = |ext_d[23:0];
        end
    end

    // ---------------- ADDSUB ----------------
    logic [27:0] op_a_d, op_b_d, sum_d;

    always_comb begin
        op_a_d = {1'b0, mbig_q, 3'b000};
        op_b_d = {1'b0, msml_q, sticky_q};
        // |big| >= |small| so the difference never goes negative
        sum_d  = eff_sub_q ? (op_a_d - op_b_d) : (op_a_d + op_b_d);
    end

    // ---------------- NORM ----------------
    logic [4:0]        lzc_d;
    logic [26:0]       nrm_d;
    logic signed [9:0] nexp_d;
    logic              zero_d, uf_d;

    always_comb begin
        lzc_d = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) lzc_d = 5'(26 - i);
        end
        zero_d = (sum_q == 28'd0);
        if (sum_q[27]) begin
            nrm_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
            nexp_d = exp_q + 10'sd1;
        end else begin
            nrm_d  = sum_q[26:0] << lzc_d;
            nexp_d = exp_q - $signed({5'd0, lzc_d});
        end
        uf_d = !zero_d && (nexp_d <= 10'sd0);
    end

    // ---------------- ROUND ----------------
    logic              up_d;
    logic [24:0]       mant_d;
    logic signed [9:0] rexp_d;
    logic [22:0]       frac_d;
    logic              inexact_d;
    logic [31:0]       res_d;
    logic [2:0]        flags_d;

    always_comb begin
        inexact_d = nrm_q[2] | nrm_q[1] | nrm_q[0];
`ifdef FP32_ADDSUB_RNE_EN
        up_d      = nrm_q[2] & (nrm_q[1] | nrm_q[0] | nrm_q[3]);
`else
        up_d      = 1'b0;
`endif
        mant_d    = {1'b0, nrm_q[26:3]} + {24'd0, up_d};
        // rounding carry-out leaves 1.000..., so the fraction is all zeros in that case
        rexp_d    = mant_d[24] ? (exp_q + 10'sd1) : exp_q;
        frac_d    = mant_d[24] ? mant_d[23:1] : mant_d[22:0];
        if (zero_q) begin
            res_d   = 32'd0;
            flags_d = 3'b000;
        end else if (uf_q) begin
            res_d   = {sign_q, 31'd0};
            flags_d = 3'b001;
        end else if (rexp_d >= 10'sd255) begin
            res_d   = {sign_q, 8'hFF, 23'd0};
            flags_d = {1'b0, 1'b1, inexact_d};
        end else begin
            res_d   = {sign_q, rexp_d[7:0], frac_d};
            flags_d = {1'b0, 1'b0, inexact_d};
        end
    end

    // ---------------- FSM and state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            spec_q      <= 1'b0;
            spec_inv_q  <= 1'b0;
            spec_res_q  <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            mbig_q      <= '0;
            msml_q      <= '0;
            sticky_q    <= 1'b0;
            sum_q       <= '0;
            nrm_q       <= '0;
            zero_q      <= 1'b0;
            uf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= add1_i;
                        b_q        <= add2_i;
                        cmd_q      <= command_i;
                        in_ready_q <= 1'b0;
                        state_q    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sa_q       <= a_q[31];
                    sb_q       <= sb_eff_d;
                    ea_q       <= a_q[30:23];
                    eb_q       <= b_q[30:23];
                    ma_q       <= ma_d;
                    mb_q       <= mb_d;
                    spec_q     <= spec_d;
                    spec_inv_q <= spec_inv_d;
                    spec_res_q <= spec_res_d;
                    state_q    <= ALIGN;
                end
                ALIGN: begin
                    if (spec_q) begin
                        result_q    <= spec_res_q;
                        flags_q     <= {spec_inv_q, 2'b00};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        sign_q    <= big_s_d;
                        eff_sub_q <= big_s_d != small_s_d;
                        exp_q     <= $signed({2'b00, big_e_d});
                        mbig_q    <= big_m_d;
                        msml_q    <= al_m_d;
                        sticky_q  <= al_st_d;
                        state_q   <= ADDSUB;
                    end
                end
                ADDSUB: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    nrm_q   <= nrm_d;
                    exp_q   <= nexp_d;
                    zero_q  <= zero_d;
                    uf_q    <= uf_d;
                    state_q <= ROUND;
                end
                ROUND: begin
                    result_q    <= res_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign exc_flags_o = flags_q;

endmodule

// File: tb/tb_fp32_addsub_seq.sv
module tb_fp32_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] add1, add2;
    logic        command;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  exc_flags;

    int errors = 0;
    int checks = 0;

`ifdef FP32_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fp32_addsub_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .add1_i      (add1),
        .add2_i      (add2),
        .command_i   (command),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .exc_flags_o (exc_flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Exact-arithmetic reference: both operands placed on a wide integer grid, added exactly,
    // then rounded once. Returns {flags, result}.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic cmd);
        logic         sa, sb, st, inexact, up;
        int           ea, eb, et, diff, p, e, sh;
        logic [23:0]  ma, mb, mt;
        logic [127:0] va, vb, r, rem, half;
        logic [24:0]  mant;
        sa = a[31];
        sb = b[31] ^ ~cmd;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {3'b100, 32'h7FC00000};
        if (ea == 255 && eb == 255 && sa != sb) return {3'b100, 32'h7FC00000};
        if (ea == 255) return {3'b000, sa, 8'hFF, 23'd0};
        if (eb == 255) return {3'b000, sb, 8'hFF, 23'd0};
        ma = (ea != 0) ? {1'b1, a[22:0]} : 24'd0;
        mb = (eb != 0) ? {1'b1, b[22:0]} : 24'd0;
        if (eb > ea || (eb == ea && mb > ma)) begin
            st = sa; sa = sb; sb = st;
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        diff = ea - eb;
        va = {104'd0, ma} << 80;
        // a tail 80+ binades down only matters as "nonzero", so a single unit stands in for it
        if (diff > 80) vb = (mb != 0) ? 128'd1 : 128'd0;
        else           vb = ({104'd0, mb} << 80) >> diff;
        r = (sa == sb) ? (va + vb) : (va - vb);
        if (r == 0) return 35'd0;
        p = 0;
        for (int i = 0; i < 128; i++) if (r[i]) p = i;
        e = ea + p - 103;
        sh = p - 23;
        mant = 25'(r >> sh);
        rem = r & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
        inexact = (rem != 0);
        if (e <= 0) return {3'b001, sa, 31'd0};
        up = RNE && ((rem > half) || (rem == half && mant[0]));
        mant = mant + {24'd0, up};
        if (mant[24]) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) return {2'b01, inexact, sa, 8'hFF, 23'd0};
        return {2'b00, inexact, sa, 8'(e), mant[22:0]};
    endfunction

    // One full transaction; stall < 0 means out_ready is already high when out_valid rises.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cmd,
                          input logic [31:0] want_res, input logic [2:0] want_fl, input int want_lat,
                          input int stall);
        int lat;
        int w;
        add1 = a;
        add2 = b;
        command = cmd;
        in_valid = 1'b1;
        out_ready = (stall < 0);
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, want_lat);
        chk({tag, "_result"}, result, want_res);
        chk({tag, "_flags"}, 32'(exc_flags), 32'(want_fl));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_result"}, result, want_res);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        int          mode, ea, eb, stall;
        logic [22:0] fa, fb;
        logic [31:0] ra, rb;
        logic        rc;
        logic [34:0] want;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        add1 = 32'd0;
        add2 = 32'd0;
        command = 1'b0;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(exc_flags), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // basic arithmetic; the subtract case also confirms DONE lasts one cycle with out_ready high
        run_op("sub_basic", 32'h40800000, 32'h40000000, 1'b0, 32'h40000000, 3'b000, 5, -1);
        run_op("add_basic", 32'h40800000, 32'h40000000, 1'b1, 32'h40C00000, 3'b000, 5, 0);
        // rounding
        run_op("round_tie", 32'h3F800001, 32'h3F800002, 1'b1,
               RNE ? 32'h40000002 : 32'h40000001, 3'b001, 5, 1);
        run_op("round_even", 32'h3FC00001, 32'h3FC02000, 1'b1, 32'h40401000, 3'b001, 5, 0);
        // cancellation and specials
        run_op("cancel", 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, 5, 0);
        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100, 2, 0);
        run_op("nan_in", 32'h7FA00000, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100, 2, 0);
        run_op("single_inf", 32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 3'b000, 2, 0);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 3'b010, 5, 0);
        run_op("denorm_flush", 32'h00400000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000, 5, 0);

        // back-pressure: hold the result for 10 cycles while a new request is offered and ignored
        add1 = 32'h40800000;
        add2 = 32'h40000000;
        command = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_latency", lat, 5);
        add1 = 32'h3F800000;
        add2 = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_result", result, 32'h40C00000);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("bp_no_ghost_op", 32'(out_valid), 32'd0);
        end

        // reset while the operation sits in ALIGN
        add1 = 32'h3F800000;
        add2 = 32'h3F800000;
        command = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_flags", 32'(exc_flags), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rst_aborted", 32'(out_valid), 32'd0);
        end
        run_op("post_reset", 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 5, 0);

        // random normal operands against the exact reference
        for (int n = 0; n < 1000; n++) begin
            mode = int'($urandom_range(0, 3));
            ea = int'($urandom_range(20, 235));
            eb = int'($urandom_range(20, 235));
            fa = 23'($urandom);
            fb = 23'($urandom);
            if (mode == 1) begin
                eb = ea + int'($urandom_range(0, 6)) - 3;
            end else if (mode == 2) begin
                eb = ea;
                fb = fa ^ 23'($urandom_range(0, 255));
            end else if (mode == 3) begin
                ea = int'($urandom_range(240, 254));
                eb = int'($urandom_range(240, 254));
            end
            ra = {1'($urandom), 8'(ea), fa};
            rb = {1'($urandom), 8'(eb), fb};
            rc = 1'($urandom);
            want = ref_model(ra, rb, rc);
            stall = int'($urandom_range(0, 4)) - 1;
            run_op("rnd", ra, rb, rc, want[31:0], want[34:32], 5, stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
